// File: rtl/e203_dtcm_sram_initiator.sv
// ICB-to-SRAM bridge for the E203 DTCM: single-cycle SRAM access with a 2-entry
// fall-through response FIFO, credit-based command flow control and light-sleep entry.
module e203_dtcm_sram_initiator #(
  parameter int          AW        = 14,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          LS_IDLE   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [31:0]       icb_cmd_addr,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [DW/8-1:0]   icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW/8-1:0]   ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              ram_sd,
  output logic              ram_ds,
  output logic              ram_ls
);

  localparam int         MW        = DW / 8;
  localparam logic [7:0] IDLE_LAST = 8'(LS_IDLE - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_LS,
    ST_WAKE
  } state_e;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  state_e     state;
  logic [7:0] idle_cnt;

  logic inflight;
  logic inflight_rd;
  logic inflight_err;

  rsp_t       fifo_mem [2];
  logic       wptr;
  logic       rptr;
  logic [1:0] fifo_count;

  logic [1:0] credits;
  logic       in_region;
  logic       cmd_hs;
  logic       ram_access;
  logic       ram_write;
  logic       push;
  logic       pop;
  rsp_t       push_data;
  rsp_t       head;

  // Byte-offset bits never reach a word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^icb_cmd_addr[1:0];

  assign in_region = (icb_cmd_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign credits   = fifo_count + {1'b0, inflight};

  // Ready depends only on registered state, never on icb_rsp_ready.
  assign icb_cmd_ready = rst_n && (state == ST_ACTIVE) && (credits < 2'd2);
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
  assign ram_access    = cmd_hs & in_region;
  assign ram_write     = ram_access & ~icb_cmd_read;

  assign ram_cs   = ram_access;
  assign ram_we   = ram_write;
  assign ram_addr = icb_cmd_addr[AW+1:2];
  assign ram_wem  = ram_write ? icb_cmd_wmask : {MW{1'b0}};
  assign ram_din  = icb_cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;
  assign ram_ls   = (state == ST_LS);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_data       = '0;
    push_data.err   = inflight_err;
    if (inflight_rd) push_data.rdata = ram_dout;
  end

  assign push = inflight;

  // Fall-through: with the FIFO empty the entry being pushed is the head,
  // giving a one-cycle command-to-response latency.
  assign head          = (fifo_count != 2'd0) ? fifo_mem[rptr] : push_data;
  assign icb_rsp_valid = rst_n & ((fifo_count != 2'd0) | inflight);
  assign icb_rsp_rdata = icb_rsp_valid ? head.rdata : '0;
  assign icb_rsp_err   = icb_rsp_valid & head.err;
  assign pop           = icb_rsp_valid & icb_rsp_ready;

  // NOTE: FIFO storage has no reset; the count gates every read of it, which
  // keeps the reset tree off the data bits.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_ACTIVE;
      idle_cnt     <= 8'd0;
      inflight     <= 1'b0;
      inflight_rd  <= 1'b0;
      inflight_err <= 1'b0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      fifo_count   <= 2'd0;
    end else begin
      inflight     <= cmd_hs;
      inflight_rd  <= ram_access & icb_cmd_read;
      inflight_err <= cmd_hs & ~in_region;

      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        ST_ACTIVE: begin
          if (cmd_hs || inflight) begin
            idle_cnt <= 8'd0;
          end else if (idle_cnt == IDLE_LAST) begin
            // Saturate here until buffered responses have drained.
            if (fifo_count == 2'd0) begin
              state    <= ST_LS;
              idle_cnt <= 8'd0;
            end
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        ST_LS: begin
          if (icb_cmd_valid) state <= ST_WAKE;
        end
        ST_WAKE: begin
          state    <= ST_ACTIVE;
          idle_cnt <= 8'd0;
        end
        default: begin
          state    <= ST_ACTIVE;
          idle_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e203_dtcm_sram_initiator.sv
// Directed bench for e203_dtcm_sram_initiator with a byte-masked SRAM model.
module tb_e203_dtcm_sram_initiator;

  logic        clk;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        ram_cs;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_sd;
  logic        ram_ds;
  logic        ram_ls;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:63];

  e203_dtcm_sram_initiator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wem       (ram_wem),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .ram_sd        (ram_sd),
    .ram_ds        (ram_ds),
    .ram_ls        (ram_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read-before-write, data valid one cycle after cs.
  always @(posedge clk) begin
    if (ram_cs) begin
      ram_dout <= mem[ram_addr[5:0]];
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm, input logic rr);
    @(negedge clk);
    rst_n         = rst;
    icb_cmd_valid = v;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    icb_rsp_ready = rr;
    #1;
  endtask

  task automatic idle(input logic rr);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rr);
  endtask

  task automatic rd(input logic [31:0] a, input logic rr);
    drive(1'b1, 1'b1, 1'b1, a, 32'h0, 4'h0, rr);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    drive(1'b1, 1'b1, 1'b0, a, wd, wm, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0; icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1'b0;

    // Reset with a pending command: nothing may reach the RAM or the response port.
    drive(1'b0, 1'b1, 1'b1, 32'h9000_0000, 32'h0, 4'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h9000_0000, 32'h0, 4'h0, 1'b1);
    check("rst_cs", ram_cs, 1'b0);
    check("rst_we", ram_we, 1'b0);
    check("rst_rsp_valid", icb_rsp_valid, 1'b0);
    check("rst_rsp_rdata", icb_rsp_rdata, 32'h0);
    check("rst_rsp_err", icb_rsp_err, 1'b0);
    check("rst_ls", ram_ls, 1'b0);
    check("rst_sd_ds", {ram_sd, ram_ds}, 2'b00);

    idle(1'b1);
    check("post_rst_ready", icb_cmd_ready, 1'b1);
    check("post_rst_rsp_valid", icb_rsp_valid, 1'b0);

    // Full-word write.
    wr(32'h9000_0010, 32'hDEAD_BEEF, 4'hF);
    check("w1_ready", icb_cmd_ready, 1'b1);
    check("w1_cs", ram_cs, 1'b1);
    check("w1_we", ram_we, 1'b1);
    check("w1_addr", ram_addr, 14'd4);
    check("w1_wem", ram_wem, 4'hF);
    check("w1_din", ram_din, 32'hDEAD_BEEF);
    check("w1_no_rsp_yet", icb_rsp_valid, 1'b0);
    idle(1'b1);
    check("w1_rsp_valid", icb_rsp_valid, 1'b1);
    check("w1_rsp_err", icb_rsp_err, 1'b0);
    check("w1_rsp_rdata", icb_rsp_rdata, 32'h0);

    // Partial write: low two bytes of word 5.
    wr(32'h9000_0014, 32'h1122_3344, 4'h3);
    check("w2_addr", ram_addr, 14'd5);
    check("w2_wem", ram_wem, 4'h3);
    idle(1'b1);
    check("w2_rsp_valid", icb_rsp_valid, 1'b1);

    // Read back word 4.
    rd(32'h9000_0010, 1'b1);
    check("r1_cs", ram_cs, 1'b1);
    check("r1_we", ram_we, 1'b0);
    check("r1_wem", ram_wem, 4'h0);
    check("r1_addr", ram_addr, 14'd4);
    idle(1'b1);
    check("r1_rsp_valid", icb_rsp_valid, 1'b1);
    check("r1_rsp_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
    check("r1_rsp_err", icb_rsp_err, 1'b0);

    // Out-of-region read.
    rd(32'h8000_0000, 1'b1);
    check("oor_ready", icb_cmd_ready, 1'b1);
    check("oor_cs", ram_cs, 1'b0);
    idle(1'b1);
    check("oor_rsp_valid", icb_rsp_valid, 1'b1);
    check("oor_rsp_err", icb_rsp_err, 1'b1);
    check("oor_rsp_rdata", icb_rsp_rdata, 32'h0);
    idle(1'b1);
    check("quiet_rsp_valid", icb_rsp_valid, 1'b0);
    check("quiet_cs", ram_cs, 1'b0);

    // Backpressure: only two commands fit, third waits.
    rd(32'h9000_0000, 1'b0);
    check("bp_a_ready", icb_cmd_ready, 1'b1);
    rd(32'h9000_0004, 1'b0);
    check("bp_b_ready", icb_cmd_ready, 1'b1);
    check("bp_b_rdata", icb_rsp_rdata, 32'h1000_0000);
    rd(32'h9000_0008, 1'b0);
    check("bp_c_ready", icb_cmd_ready, 1'b0);
    check("bp_c_cs", ram_cs, 1'b0);
    check("bp_c_rdata_stable", icb_rsp_rdata, 32'h1000_0000);
    rd(32'h9000_0008, 1'b1);
    check("bp_d_ready_full", icb_cmd_ready, 1'b0);
    check("bp_d_rdata", icb_rsp_rdata, 32'h1000_0000);
    rd(32'h9000_0008, 1'b1);
    check("bp_e_ready", icb_cmd_ready, 1'b1);
    check("bp_e_rdata", icb_rsp_rdata, 32'h1000_0001);
    idle(1'b1);
    check("bp_f_valid", icb_rsp_valid, 1'b1);
    check("bp_f_rdata", icb_rsp_rdata, 32'h1000_0002);

    // Streaming 16 reads of words 16..31.
    for (int i = 0; i < 16; i++) begin
      rd(32'h9000_0040 + 32'(4 * i), 1'b1);
      check($sformatf("st_ready_%0d", i), icb_cmd_ready, 1'b1);
      if (i > 0) check($sformatf("st_rdata_%0d", i - 1), icb_rsp_rdata, 32'h1000_0010 + 32'(i - 1));
    end
    idle(1'b1);
    check("st_rdata_15", icb_rsp_rdata, 32'h1000_001F);

    // Light sleep after eight idle cycles, then wake.
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check($sformatf("ls_awake_%0d", i), ram_ls, 1'b0);
    end
    rd(32'h9000_0014, 1'b1);
    check("ls_on", ram_ls, 1'b1);
    check("ls_ready", icb_cmd_ready, 1'b0);
    rd(32'h9000_0014, 1'b1);
    check("wake_ls", ram_ls, 1'b0);
    check("wake_ready", icb_cmd_ready, 1'b0);
    rd(32'h9000_0014, 1'b1);
    check("wake_accept", icb_cmd_ready, 1'b1);
    check("wake_cs", ram_cs, 1'b1);
    idle(1'b1);
    check("wake_rsp_rdata", icb_rsp_rdata, 32'h1000_3344);

    // Reset with two responses buffered.
    rd(32'h9000_0000, 1'b0);
    rd(32'h9000_0004, 1'b0);
    idle(1'b0);
    check("mr_ready_full", icb_cmd_ready, 1'b0);
    idle(1'b0);
    check("mr_buffered", icb_rsp_valid, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    check("mr_rsp_dropped", icb_rsp_valid, 1'b0);
    idle(1'b1);
    check("mr_ready", icb_cmd_ready, 1'b1);
    check("mr_no_stale", icb_rsp_valid, 1'b0);
    rd(32'h9000_0008, 1'b1);
    check("mr_cs", ram_cs, 1'b1);
    idle(1'b1);
    check("mr_rsp_valid", icb_rsp_valid, 1'b1);
    check("mr_rsp_rdata", icb_rsp_rdata, 32'h1000_0002);
    idle(1'b1);
    check("mr_drained", icb_rsp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
